// File: rtl/serial_sort_engine.sv
// Odd-even transposition sorter: loads M words of N bits, sorts them in place, streams them out.
// Optional macro SORT_EARLY_EXIT_EN ends SORT after two consecutive phases without a swap.
module serial_sort_engine #(
  parameter int unsigned N = 7,
  parameter int unsigned M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         desc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);
  localparam int unsigned IW = $clog2(M);
  localparam logic [IW-1:0] LAST = IW'(M - 1);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_UNLOAD} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  r_q [M];
  logic [N-1:0]  r_d [M];
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] p_q, p_d;
  logic          dir_q, dir_d;
  logic          in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [N-1:0]  out_data_q;
`ifdef SORT_EARLY_EXIT_EN
  logic          any_swap;
  logic          swapped_q, swapped_d;
`endif

  // Next-state: load one word, run one transposition phase, or emit one word per cycle.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    idx_d   = idx_q;
    p_d     = p_q;
    dir_d   = dir_q;
`ifdef SORT_EARLY_EXIT_EN
    any_swap  = 1'b0;
    swapped_d = swapped_q;
`endif
    unique case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          r_d[idx_q] = in_data;
          if (idx_q == '0) dir_d = desc;
          if (idx_q == LAST) begin
            idx_d   = '0;
            p_d     = '0;
            state_d = S_SORT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SORT: begin
        // Pairs start at even index on even phases, odd index on odd phases.
        for (int i = 0; i < int'(M) - 1; i++) begin
          if ((1'(i) == p_q[0]) &&
              ((dir_q && (r_q[i] < r_q[i+1])) || (!dir_q && (r_q[i] > r_q[i+1])))) begin
            r_d[i]   = r_q[i+1];
            r_d[i+1] = r_q[i];
`ifdef SORT_EARLY_EXIT_EN
            any_swap = 1'b1;
`endif
          end
        end
        p_d = p_q + 1'b1;
        if (p_q == LAST) state_d = S_UNLOAD;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = any_swap;
        if ((p_q != '0) && !any_swap && !swapped_q) state_d = S_UNLOAD;
`endif
      end
      S_UNLOAD: begin
        if (out_ready && out_valid_q) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      for (int i = 0; i < int'(M); i++) r_q[i] <= '0;
      idx_q       <= '0;
      p_q         <= '0;
      dir_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      p_q         <= p_d;
      dir_q       <= dir_d;
      in_ready_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_UNLOAD);
      out_last_q  <= (state_d == S_UNLOAD) && (idx_d == LAST);
      busy_q      <= (state_d != S_LOAD);
      out_data_q  <= r_d[idx_d];
`ifdef SORT_EARLY_EXIT_EN
      swapped_q   <= swapped_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/serial_sort_engine.md
# serial_sort_engine

- Parametrised odd-even transposition (parallel bubble) sorter.
- Collects M words of width N over a valid/ready input stream, sorts them in place in a register array, then streams them out in order over a valid/ready output stream.
- Supersedes the fixed four-input, single-pass swapper chain.
- Adds:
  - arbitrary element count;
  - a guaranteed complete sort;
  - selectable direction;
  - backpressure on both sides.

## Interface

Parameters:
- N, 7, data word width in bits (unsigned compare).
- M, 8, elements per batch; legal range 2..256.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  engine accepts a word this cycle; high only in LOAD.
- in_data  input  N  element to load.
- desc  input  1  direction: 0 ascending, 1 descending; sampled with the first accepted word of a batch.
- out_valid  output  1  out_data is valid; high only in UNLOAD.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  N  current sorted element.
- out_last  output  1  high with the M-th output element.
- busy  output  1  high in SORT and UNLOAD.

## Operation

- Storage: array r[0..M-1] of N-bit registers, a load/unload index of width clog2(M), a phase counter, and a latched direction bit.
- State machine LOAD -> SORT -> UNLOAD -> LOAD. Reset enters LOAD.
- LOAD:
  - Each in_valid&in_ready handshake writes in_data to r[idx] and increments idx.
  - The first handshake (idx=0) also latches desc.
  - The handshake at idx=M-1 clears idx and moves to SORT.
- SORT, one phase per cycle, phase counter p from 0:
  - Even p compares disjoint pairs (0,1),(2,3),…
  - Odd p compares pairs (1,2),(3,4),…
  - For M odd, the unpaired end element holds its value.
  - Ascending mode swaps a pair when r[i] > r[i+1] strictly; descending mode swaps when r[i] < r[i+1] strictly.
  - Equal values never swap, so the sort is stable.
  - After phase p=M-1, the next state is UNLOAD.
- UNLOAD:
  - out_data=r[idx] and out_valid=1.
  - On out_valid&out_ready, idx increments.
  - out_last=1 when idx=M-1.
  - The handshake with out_last clears idx and returns to LOAD.
- in_data/in_valid are ignored outside LOAD; out_ready is ignored outside UNLOAD.

## Timing

- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
  - r[] cleared to 0; idx=0, p=0, latched direction=0.
- Reset mid-batch discards all data asynchronously; the engine is back in LOAD with in_ready=1 as soon as rst_n is low.
- in_ready, out_valid, out_last and busy are registered state decodes, with no combinational path from in_valid or out_ready.
- Load throughput: one word per cycle when in_valid is held high; M accepted words take M cycles.
- SORT duration:
  - Without the macro, exactly M cycles.
  - busy rises the cycle after the last input handshake.
- out_valid rises the cycle after the final SORT phase.
- Output throughput: one word per cycle with out_ready held high. out_valid stays high and out_data is stable while out_ready=0.
- in_ready rises the cycle after the out_last handshake. There is no overlap of LOAD with UNLOAD.
- Minimum batch period without the macro is 3M cycles.

## Configuration

- Macro: SORT_EARLY_EXIT_EN.
- When defined:
  - SORT tracks a per-phase swap flag.
  - SORT terminates after the first phase p≥1 for which phases p-1 and p both performed zero swaps; the array is then provably sorted.
  - SORT therefore lasts between 2 and M cycles, and already-sorted input takes 2 cycles.
  - The M-phase limit still applies.
- When undefined:
  - No swap-flag logic is built.
  - SORT is always exactly M cycles regardless of data.

## Test plan

- M=8, N=7, desc=0, load 7,6,5,4,3,2,1,0 back-to-back -> output 0..7, out_last on the 8th word, busy high for 8+8 cycles; SORT lasts 8 cycles with the macro on or off.
- Presorted 0..7, desc=0 -> output 0..7; SORT lasts 2 cycles with SORT_EARLY_EXIT_EN and 8 cycles without.
- desc=1, load 3,100,3,0,127,64,1,100 -> output 127,100,100,64,3,3,1,0.
- Duplicates: load 5,5,5,5,5,5,5,5 -> all outputs 5; with the macro, SORT lasts 2 cycles.
- Backpressure:
  - out_ready toggles 1,0,0,1,… -> out_data holds while out_ready=0, there is no loss or duplication, and in_ready stays 0 until after out_last.
  - in_valid gaps during LOAD -> only handshaken words are stored.
- Reset asserted during the 4th SORT cycle -> all outputs return to their reset values immediately. A new batch 9,2,4,1,8,3,7,0 then sorts to 0,1,2,3,4,7,8,9 with no residue from the aborted batch.
